// File: rtl/bp_nonsynth_cosim_sched.sv
// Co-simulation commit scheduler.
// Collects commit records from several cores, picks one per cycle in
// round-robin order and presents it through a single registered output
// entry to the downstream stepper. Each core carries a saturating retire
// counter; once a core reaches the configured cap its stream is closed,
// and when every stream is closed the scheduler drains and parks in DONE.
module bp_nonsynth_cosim_sched #(
  parameter int num_core_p  = 4,
  parameter int pkt_width_p = 128,
  localparam int core_w     = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic [31:0]                       instr_cap_i,
  input  logic [num_core_p-1:0]             core_v_i,
  input  logic [num_core_p*pkt_width_p-1:0] core_pkt_i,
  input  logic [num_core_p-1:0]             core_instret_i,
  output logic [num_core_p-1:0]             core_yumi_o,
  output logic                              step_v_o,
  output logic [core_w-1:0]                 step_core_o,
  output logic [pkt_width_p-1:0]            step_pkt_o,
  input  logic                              step_ready_i,
  output logic [num_core_p-1:0]             finish_o,
  output logic                              done_o,
  output logic [1:0]                        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [core_w-1:0] last_idx = core_w'(num_core_p - 1);

  state_e                   state_r;
  logic                     done_r;
  logic [core_w-1:0]        last_r;
  logic [31:0]              cnt_r [num_core_p];
  logic [num_core_p-1:0]    finish_r;

  logic                     step_v_r;
  logic [core_w-1:0]        step_core_r;
  logic [pkt_width_p-1:0]   step_pkt_r;

  logic [num_core_p-1:0]    at_cap;
  logic [num_core_p-1:0]    eligible;
  logic                     load_ok;
  logic                     found;
  logic                     grant_v;
  logic [core_w-1:0]        idx;
  logic [core_w-1:0]        sel;
  logic [pkt_width_p-1:0]   grant_pkt;

  // A core is closed for new grants once finished, and also in the single
  // cycle where its counter has just reached the cap but finish_o is not
  // yet registered; otherwise a back-to-back stream would slip one extra
  // record past the cap.
  always_comb begin
    at_cap   = '0;
    eligible = '0;
    for (int i = 0; i < num_core_p; i++) begin
      at_cap[i]   = (instr_cap_i != 32'd0) && (cnt_r[i] == instr_cap_i);
      eligible[i] = core_v_i[i] & ~finish_r[i] & ~at_cap[i];
    end
  end

  // Round-robin search starting one past the last granted core, qualified
  // by FSM state and by room in the output entry.
  always_comb begin
    load_ok = ~step_v_r | step_ready_i;
    found   = 1'b0;
    sel     = '0;
    idx     = last_r;
    for (int k = 0; k < num_core_p; k++) begin
      idx = (idx == last_idx) ? '0 : idx + 1'b1;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    grant_v = found & (state_r == RUN) & load_ok;
  end

  // Record of the selected core and the one-hot consume strobe.
  always_comb begin
    grant_pkt   = '0;
    core_yumi_o = '0;
    for (int i = 0; i < num_core_p; i++) begin
      if (sel == core_w'(i)) begin
        grant_pkt = core_pkt_i[i*pkt_width_p +: pkt_width_p];
      end
    end
    if (grant_v) begin
      core_yumi_o[sel] = 1'b1;
    end
  end

  // Output entry: loads on grant (also when the current record leaves in
  // the same cycle, so no bubble), empties on acceptance without reload.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      step_v_r    <= 1'b0;
      step_core_r <= '0;
      step_pkt_r  <= '0;
    end else if (grant_v) begin
      step_v_r    <= 1'b1;
      step_core_r <= sel;
      step_pkt_r  <= grant_pkt;
    end else if (step_ready_i) begin
      step_v_r    <= 1'b0;
    end
  end

  // Round-robin pointer follows the most recent grant.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      last_r <= last_idx;
    end else if (grant_v) begin
      last_r <= sel;
    end
  end

  // Per-core saturating retire counters; traps are consumed but not counted.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < num_core_p; i++) begin
        cnt_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (core_yumi_o[i] && core_instret_i[i] && (cnt_r[i] != 32'hFFFF_FFFF)) begin
          cnt_r[i] <= cnt_r[i] + 32'd1;
        end
      end
    end
  end

  // Sticky finish flags, set the cycle after a counter equals a nonzero cap;
  // an exact-match compare means counters already past a lowered cap never
  // finish.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      finish_r <= '0;
    end else begin
      finish_r <= finish_r | at_cap;
    end
  end

  // Scheduler state machine with registered done flag.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en_i) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (!en_i) begin
            state_r <= IDLE;
          end else if (&finish_r) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (!step_v_r) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign step_v_o    = step_v_r;
  assign step_core_o = step_core_r;
  assign step_pkt_o  = step_pkt_r;
  assign finish_o    = finish_r;
  assign done_o      = done_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_bp_nonsynth_cosim_sched.sv
// Bench for the co-simulation commit scheduler: four cores, 128-bit records.
// Each core's source is a sequence counter advanced on consume; a scoreboard
// queues every granted record and checks it when the stepper accepts it.
module tb_bp_nonsynth_cosim_sched;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         en_i;
  logic [31:0]  instr_cap;
  logic [3:0]   core_v;
  logic [511:0] core_pkt;
  logic [3:0]   core_instret;
  logic [3:0]   core_yumi;
  logic         step_v;
  logic [1:0]   step_core;
  logic [127:0] step_pkt;
  logic         step_ready;
  logic [3:0]   finish;
  logic         done;
  logic [1:0]   state;

  int vectors     = 0;
  int miscompares = 0;

  int           seq [4];
  int           trap_at [4];
  logic [3:0]   yumi_lat;
  logic [129:0] exp_q [$];

  bp_nonsynth_cosim_sched #(.num_core_p(4), .pkt_width_p(128)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .en_i           (en_i),
    .instr_cap_i    (instr_cap),
    .core_v_i       (core_v),
    .core_pkt_i     (core_pkt),
    .core_instret_i (core_instret),
    .core_yumi_o    (core_yumi),
    .step_v_o       (step_v),
    .step_core_o    (step_core),
    .step_pkt_o     (step_pkt),
    .step_ready_i   (step_ready),
    .finish_o       (finish),
    .done_o         (done),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_pkt(input int c, input int s);
    return {32'hC05E_C05E, 32'(c * 7 + 1), 32'(c), 32'(s)};
  endfunction

  // Head record of each core and its retire/trap flag.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      core_pkt[i*128 +: 128] = mk_pkt(i, seq[i]);
      core_instret[i]        = (seq[i] != trap_at[i]);
    end
  end

  // Sources advance to the next record after a consume edge.
  always @(posedge clk) begin
    #1;
    if (reset_i) begin
      for (int i = 0; i < 4; i++) begin
        if (yumi_lat[i]) seq[i] = seq[i] + 1;
      end
    end
  end

  // Scoreboard: check accepted output, then queue newly granted records.
  always @(negedge clk) begin
    logic [129:0] ex;
    yumi_lat = reset_i ? core_yumi : 4'b0000;
    if (reset_i && step_v && step_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got core %0d pkt %h, required no record", step_core, step_pkt);
      end else begin
        ex = exp_q.pop_front();
        if ({step_core, step_pkt} !== ex) begin
          miscompares++;
          $display("FAIL sb_record: got core %0d pkt %h, required core %0d pkt %h",
                   step_core, step_pkt, ex[129:128], ex[127:0]);
        end
      end
    end
    if (reset_i) begin
      for (int i = 0; i < 4; i++) begin
        if (core_yumi[i]) exp_q.push_back({2'(i), mk_pkt(i, seq[i])});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset_i = 1'b0;
    #1 exp_q.delete();
    en_i       = 1'b0;
    core_v     = 4'b0000;
    step_ready = 1'b1;
    instr_cap  = 32'd0;
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic idle_out();
    @(posedge clk);
    #1;
    core_v = 4'b0000;
    en_i   = 1'b0;
    step_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i = 1'b0; en_i = 1'b1; core_v = 4'b1111; step_ready = 1'b1; instr_cap = 32'd0;
    #12;
    vectors++;
    if ({state, step_v, core_yumi, finish, done} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got state %0d v %b yumi %b fin %b done %b, required all 0",
               state, step_v, core_yumi, finish, done);
    end
    vectors++;
    if ({step_core, step_pkt} !== 130'd0) begin
      miscompares++;
      $display("FAIL reset_data: got core %0d pkt %h, required 0", step_core, step_pkt);
    end
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    vectors++;
    if (core_yumi !== 4'b0000 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_first_cycle: got yumi %b state %0d, required 0000 IDLE", core_yumi, state);
    end
    @(negedge clk);
    vectors++;
    if (core_yumi !== 4'b0001 || state !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_first_grant: got yumi %b state %0d, required 0001 RUN", core_yumi, state);
    end
    idle_out();
  endtask

  task automatic test_round_robin();
    do_reset();
    en_i = 1'b1; core_v = 4'b1111; step_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (core_yumi !== 4'(1 << (k % 4))) begin
        miscompares++;
        $display("FAIL rr_yumi k=%0d: got %b, required %b", k, core_yumi, 4'(1 << (k % 4)));
      end
      if (k > 0) begin
        vectors++;
        if (step_v !== 1'b1 || step_core !== 2'((k - 1) % 4)) begin
          miscompares++;
          $display("FAIL rr_no_bubble k=%0d: got v %b core %0d, required v 1 core %0d",
                   k, step_v, step_core, (k - 1) % 4);
        end
      end
    end
    idle_out();
  endtask

  task automatic test_backpressure();
    int s0;
    do_reset();
    s0 = seq[2];
    en_i = 1'b1; core_v = 4'b0100; step_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_yumi !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_first_yumi: got %b, required 0100", core_yumi);
    end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (core_yumi !== 4'b0000 || step_v !== 1'b1 || step_core !== 2'd2 || step_pkt !== mk_pkt(2, s0)) begin
        miscompares++;
        $display("FAIL bp_hold k=%0d: got yumi %b v %b core %0d pkt %h, required 0000 1 2 %h",
                 k, core_yumi, step_v, step_core, step_pkt, mk_pkt(2, s0));
      end
    end
    @(posedge clk);
    #1 step_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (core_yumi !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_resume_yumi: got %b, required 0100", core_yumi);
    end
    idle_out();
  endtask

  task automatic test_cap();
    int gcount = 0;
    do_reset();
    instr_cap = 32'd3; en_i = 1'b1; core_v = 4'b0010; step_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gcount += int'(core_yumi[1]);
      vectors++;
      if (core_yumi !== ((k < 3) ? 4'b0010 : 4'b0000)) begin
        miscompares++;
        $display("FAIL cap_yumi k=%0d: got %b, required %b", k, core_yumi, (k < 3) ? 4'b0010 : 4'b0000);
      end
      if (k == 1 || k >= 5) begin
        vectors++;
        if (finish !== ((k == 1) ? 4'b0000 : 4'b0010)) begin
          miscompares++;
          $display("FAIL cap_finish k=%0d: got %b, required %b", k, finish, (k == 1) ? 4'b0000 : 4'b0010);
        end
      end
    end
    vectors++;
    if (gcount != 3 || state !== 2'd1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL cap_summary: got grants %0d state %0d done %b, required 3 RUN 0", gcount, state, done);
    end
    @(posedge clk);
    #1 core_v = 4'b0011;
    @(negedge clk);
    vectors++;
    if (core_yumi !== 4'b0001) begin
      miscompares++;
      $display("FAIL cap_other_core: got %b, required 0001", core_yumi);
    end
    idle_out();
  endtask

  task automatic test_trap_done();
    do_reset();
    for (int i = 0; i < 4; i++) trap_at[i] = seq[i] + 1;
    instr_cap = 32'd2; en_i = 1'b1; core_v = 4'b1111; step_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      vectors++;
      if (core_yumi !== ((k < 12) ? 4'(1 << (k % 4)) : 4'b0000)) begin
        miscompares++;
        $display("FAIL trap_yumi k=%0d: got %b, required %b", k, core_yumi,
                 (k < 12) ? 4'(1 << (k % 4)) : 4'b0000);
      end
      if (k == 11) begin
        @(posedge clk);
        #1 step_ready = 1'b0;
      end
    end
    for (int w = 0; w < 10 && state !== 2'd2; w++) @(negedge clk);
    vectors++;
    if (state !== 2'd2 || step_v !== 1'b1 || finish !== 4'b1111 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_drain: got state %0d v %b fin %b done %b, required DRAIN 1 1111 0",
               state, step_v, finish, done);
    end
    @(posedge clk);
    #1 step_ready = 1'b1;
    for (int w = 0; w < 10 && done !== 1'b1; w++) @(negedge clk);
    vectors++;
    if (state !== 2'd3 || done !== 1'b1 || step_v !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_done: got state %0d done %b v %b, required DONE 1 0", state, done, step_v);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (state !== 2'd3 || core_yumi !== 4'b0000) begin
      miscompares++;
      $display("FAIL trap_terminal: got state %0d yumi %b, required DONE 0000", state, core_yumi);
    end
    for (int i = 0; i < 4; i++) trap_at[i] = -1;
    idle_out();
  endtask

  task automatic test_en_drop();
    int s0;
    do_reset();
    s0 = seq[0];
    en_i = 1'b1; core_v = 4'b0001; step_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_yumi !== 4'b0001) begin
      miscompares++;
      $display("FAIL en_first_yumi: got %b, required 0001", core_yumi);
    end
    @(posedge clk);
    #1 en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (state !== 2'd0 || step_v !== 1'b1 || step_pkt !== mk_pkt(0, s0) || core_yumi !== 4'b0000) begin
      miscompares++;
      $display("FAIL en_pending: got state %0d v %b pkt %h yumi %b, required IDLE 1 %h 0000",
               state, step_v, step_pkt, core_yumi, mk_pkt(0, s0));
    end
    @(posedge clk);
    #1 step_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (core_yumi !== 4'b0000 || step_v !== 1'b1) begin
      miscompares++;
      $display("FAIL en_deliver: got yumi %b v %b, required 0000 1", core_yumi, step_v);
    end
    @(negedge clk);
    vectors++;
    if (core_yumi !== 4'b0000 || step_v !== 1'b0) begin
      miscompares++;
      $display("FAIL en_empty: got yumi %b v %b, required 0000 0", core_yumi, step_v);
    end
    idle_out();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    en_i = 1'b1; core_v = 4'b1111; step_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (core_yumi !== 4'(1 << (k % 4))) begin
        miscompares++;
        $display("FAIL mid_yumi k=%0d: got %b, required %b", k, core_yumi, 4'(1 << (k % 4)));
      end
    end
    #2 reset_i = 1'b0;
    #1 exp_q.delete();
    vectors++;
    if ({state, step_v, core_yumi, finish, done, step_core} !== 13'd0 || step_pkt !== 128'd0) begin
      miscompares++;
      $display("FAIL mid_async_clear: got state %0d v %b yumi %b fin %b done %b core %0d pkt %h, required all 0",
               state, step_v, core_yumi, finish, done, step_core, step_pkt);
    end
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    vectors++;
    if (core_yumi !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_first_cycle: got yumi %b, required 0000", core_yumi);
    end
    @(negedge clk);
    vectors++;
    if (core_yumi !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_core0_first: got yumi %b, required 0001", core_yumi);
    end
    idle_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      seq[i]     = 16 * i;
      trap_at[i] = -1;
    end
    test_reset();
    test_round_robin();
    test_backpressure();
    test_cap();
    test_trap_done();
    test_en_drop();
    test_reset_midstream();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d undelivered records, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
